// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: captures the decode control word and operands,
// inserts a bubble on load-use hazards or a taken-branch flush, and counts both events.
module id_ex_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            id_Opcode,
  input  logic                  id_ALUSrc,
  input  logic                  id_MemtoReg,
  input  logic                  id_RegWrite,
  input  logic                  id_MemRead,
  input  logic                  id_MemWrite,
  input  logic                  id_Branch,
  input  logic [1:0]            id_ALUOp,
  input  logic [DATA_W-1:0]     id_PC,
  input  logic [DATA_W-1:0]     id_RD1,
  input  logic [DATA_W-1:0]     id_RD2,
  input  logic [DATA_W-1:0]     id_Imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [2:0]            id_Funct3,
  input  logic [6:0]            id_Funct7,
  input  logic                  flush,
  output logic                  ex_ALUSrc,
  output logic                  ex_MemtoReg,
  output logic                  ex_RegWrite,
  output logic                  ex_MemRead,
  output logic                  ex_MemWrite,
  output logic                  ex_Branch,
  output logic [1:0]            ex_ALUOp,
  output logic [DATA_W-1:0]     ex_PC,
  output logic [DATA_W-1:0]     ex_RD1,
  output logic [DATA_W-1:0]     ex_RD2,
  output logic [DATA_W-1:0]     ex_Imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [2:0]            ex_Funct3,
  output logic [6:0]            ex_Funct7,
  output logic                  ex_Valid,
  output logic                  Stall,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpBr  = 7'b1100011;

  logic                  r_alusrc, r_memtoreg, r_regwrite, r_memread, r_memwrite, r_branch;
  logic [1:0]            r_aluop;
  logic [DATA_W-1:0]     r_pc, r_rd1, r_rd2, r_imm;
  logic [REG_ADDR_W-1:0] r_rs1, r_rs2, r_rd;
  logic [2:0]            r_funct3;
  logic [6:0]            r_funct7;
  logic                  r_valid;
  logic [CNT_W-1:0]      r_bubble_cnt, r_flush_cnt;

  logic w_use_rs1, w_use_rs2;
  logic w_rs1_match, w_rs2_match;
  logic w_hazard, w_bubble;

  // LUI, JAL and unknown opcodes read no source register.
  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (id_Opcode)
      OpR, OpSw, OpBr: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OpI, OpLw: w_use_rs1 = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_rs1_match = w_use_rs1 && (r_rd == id_rs1);
    w_rs2_match = w_use_rs2 && (r_rd == id_rs2);
    w_hazard    = r_valid && r_memread && (r_rd != '0) && (w_rs1_match || w_rs2_match);
    w_bubble    = flush || w_hazard;
    // A flushed decode instruction is squashed upstream, so there is nothing to hold.
    Stall       = w_hazard && !flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alusrc   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_branch   <= 1'b0;
      r_aluop    <= 2'b00;
      r_pc       <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct3   <= '0;
      r_funct7   <= '0;
      r_valid    <= 1'b0;
    end else if (w_bubble) begin
      r_alusrc   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_branch   <= 1'b0;
      r_aluop    <= 2'b00;
      r_pc       <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct3   <= '0;
      r_funct7   <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_alusrc   <= id_ALUSrc;
      r_memtoreg <= id_MemtoReg;
      r_regwrite <= id_RegWrite;
      r_memread  <= id_MemRead;
      r_memwrite <= id_MemWrite;
      r_branch   <= id_Branch;
      r_aluop    <= id_ALUOp;
      r_pc       <= id_PC;
      r_rd1      <= id_RD1;
      r_rd2      <= id_RD2;
      r_imm      <= id_Imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_funct3   <= id_Funct3;
      r_funct7   <= id_Funct7;
      r_valid    <= 1'b1;
    end
  end

  // Saturating counters; flush takes the credit when both events coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (flush) begin
      if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end else if (w_hazard) begin
      if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign ex_ALUSrc   = r_alusrc;
  assign ex_MemtoReg = r_memtoreg;
  assign ex_RegWrite = r_regwrite;
  assign ex_MemRead  = r_memread;
  assign ex_MemWrite = r_memwrite;
  assign ex_Branch   = r_branch;
  assign ex_ALUOp    = r_aluop;
  assign ex_PC       = r_pc;
  assign ex_RD1      = r_rd1;
  assign ex_RD2      = r_rd2;
  assign ex_Imm      = r_imm;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;
  assign ex_Funct3   = r_funct3;
  assign ex_Funct7   = r_funct7;
  assign ex_Valid    = r_valid;
  assign bubble_cnt  = r_bubble_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver applies directed vectors and queues the expected
// EX contents; a monitor pops one entry per clock edge and compares.
module tb_id_ex_stage;

  localparam logic [6:0] OpR = 7'b0110011, OpI = 7'b0010011, OpLw = 7'b0000011;
  localparam logic [6:0] OpSw = 7'b0100011, OpBr = 7'b1100011, OpLui = 7'b0110111;
  localparam logic [6:0] OpJal = 7'b1101111, OpBad = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  id_Opcode;
  logic        id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch;
  logic [1:0]  id_ALUOp;
  logic [31:0] id_PC, id_RD1, id_RD2, id_Imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_Funct3;
  logic [6:0]  id_Funct7;
  logic        flush;
  logic        ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch;
  logic [1:0]  ex_ALUOp;
  logic [31:0] ex_PC, ex_RD1, ex_RD2, ex_Imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_Funct3;
  logic [6:0]  ex_Funct7;
  logic        ex_Valid, Stall;
  logic [15:0] bubble_cnt, flush_cnt;

  id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_Opcode(id_Opcode),
    .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
    .id_ALUOp(id_ALUOp), .id_PC(id_PC), .id_RD1(id_RD1), .id_RD2(id_RD2), .id_Imm(id_Imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_Funct3(id_Funct3),
    .id_Funct7(id_Funct7), .flush(flush),
    .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
    .ex_ALUOp(ex_ALUOp), .ex_PC(ex_PC), .ex_RD1(ex_RD1), .ex_RD2(ex_RD2), .ex_Imm(ex_Imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_Funct3(ex_Funct3),
    .ex_Funct7(ex_Funct7), .ex_Valid(ex_Valid), .Stall(Stall),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  op;
    logic        alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0]  aluop;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        flush, stall, bubble;
  } vec_t;

  typedef struct packed {
    logic [161:0] ex;
    logic [15:0]  bcnt, fcnt;
    logic [31:0]  tag;
  } exp_t;

  int unsigned checks = 0;
  int unsigned failures = 0;
  exp_t        q[$];
  exp_t        m_e;
  logic [15:0] exp_b = '0, exp_f = '0;
  logic [161:0] w_act;

  assign w_act = {ex_Valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
                  ex_Branch, ex_ALUOp, ex_PC, ex_RD1, ex_RD2, ex_Imm, ex_rs1, ex_rs2, ex_rd,
                  ex_Funct3, ex_Funct7};

  task automatic check(input string name, input logic [161:0] act, input logic [161:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Control bits follow a plausible decoder; data fields are derived from the PC.
  function automatic vec_t mk(input logic [6:0] op, input logic [31:0] pc,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic fl, input logic st,
                              input logic bub);
    vec_t v;
    v = '0;
    v.op = op; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.rd1 = 32'h1000_0000 + pc; v.rd2 = 32'h2000_0000 | pc; v.imm = pc ^ 32'hFFFF_0000;
    v.f3 = pc[4:2]; v.f7 = (op == OpR) ? 7'h20 : 7'h00;
    v.flush = fl; v.stall = st; v.bubble = bub;
    case (op)
      OpR:   begin v.regwrite = 1'b1; v.aluop = 2'b10; end
      OpI:   begin v.alusrc = 1'b1; v.regwrite = 1'b1; v.aluop = 2'b10; end
      OpLw:  begin v.alusrc = 1'b1; v.memtoreg = 1'b1; v.regwrite = 1'b1; v.memread = 1'b1; end
      OpSw:  begin v.alusrc = 1'b1; v.memwrite = 1'b1; end
      OpBr:  begin v.branch = 1'b1; v.aluop = 2'b01; end
      OpLui: begin v.alusrc = 1'b1; v.regwrite = 1'b1; end
      OpJal: begin v.regwrite = 1'b1; v.branch = 1'b1; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic apply(input vec_t v);
    id_Opcode = v.op; id_ALUSrc = v.alusrc; id_MemtoReg = v.memtoreg; id_RegWrite = v.regwrite;
    id_MemRead = v.memread; id_MemWrite = v.memwrite; id_Branch = v.branch; id_ALUOp = v.aluop;
    id_PC = v.pc; id_RD1 = v.rd1; id_RD2 = v.rd2; id_Imm = v.imm;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd; id_Funct3 = v.f3; id_Funct7 = v.f7;
    flush = v.flush;
  endtask

  // Drive on the falling edge, check Stall, queue the EX state expected after the next edge.
  task automatic step(input vec_t v);
    exp_t e;
    apply(v);
    #1;
    check($sformatf("stall_pc%0h", v.pc), 162'(Stall), 162'(v.stall));
    if (v.flush) begin
      if (exp_f != 16'hFFFF) exp_f = exp_f + 16'd1;
    end else if (v.bubble) begin
      if (exp_b != 16'hFFFF) exp_b = exp_b + 16'd1;
    end
    e.ex = v.bubble ? '0 : {1'b1, v.alusrc, v.memtoreg, v.regwrite, v.memread, v.memwrite,
                            v.branch, v.aluop, v.pc, v.rd1, v.rd2, v.imm, v.rs1, v.rs2, v.rd,
                            v.f3, v.f7};
    e.bcnt = exp_b;
    e.fcnt = exp_f;
    e.tag  = v.pc;
    q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m_e = q.pop_front();
      check($sformatf("ex_fields_pc%0h", m_e.tag), w_act, m_e.ex);
      check($sformatf("bubble_cnt_pc%0h", m_e.tag), 162'(bubble_cnt), 162'(m_e.bcnt));
      check($sformatf("flush_cnt_pc%0h", m_e.tag), 162'(flush_cnt), 162'(m_e.fcnt));
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t nz;
    reset = 1'b1;
    nz = mk(OpLw, 32'hDEAD_BEEF, 5'd3, 5'd4, 5'd7, 1'b0, 1'b0, 1'b0);
    nz.branch = 1'b1; nz.memwrite = 1'b1; nz.aluop = 2'b11; nz.f7 = 7'h7F;
    apply(nz);
    #12;
    check("reset_ex", w_act, '0);
    check("reset_bubble_cnt", 162'(bubble_cnt), '0);
    check("reset_flush_cnt", 162'(flush_cnt), '0);
    check("reset_stall", 162'(Stall), '0);
    @(negedge clk);
    reset = 1'b0;

    step(mk(OpR,   32'h10, 5'd1, 5'd2, 5'd3,  1'b0, 1'b0, 1'b0)); // first edge after reset
    step(mk(OpLw,  32'h14, 5'd1, 5'd0, 5'd5,  1'b0, 1'b0, 1'b0)); // lw x5
    step(mk(OpR,   32'h18, 5'd5, 5'd7, 5'd6,  1'b0, 1'b1, 1'b1)); // add x6,x5,x7 stalls
    step(mk(OpR,   32'h18, 5'd5, 5'd7, 5'd6,  1'b0, 1'b0, 1'b0)); // held add enters EX
    step(mk(OpLw,  32'h1C, 5'd2, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0)); // lw x0
    step(mk(OpR,   32'h20, 5'd0, 5'd0, 5'd9,  1'b0, 1'b0, 1'b0)); // uses x0: no stall
    step(mk(OpLw,  32'h24, 5'd1, 5'd0, 5'd5,  1'b0, 1'b0, 1'b0));
    step(mk(OpLui, 32'h28, 5'd5, 5'd5, 5'd10, 1'b0, 1'b0, 1'b0)); // lui: no source regs
    step(mk(OpLw,  32'h2C, 5'd1, 5'd0, 5'd5,  1'b0, 1'b0, 1'b0));
    step(mk(OpSw,  32'h30, 5'd2, 5'd5, 5'd0,  1'b0, 1'b1, 1'b1)); // sw rs2=x5 stalls
    step(mk(OpSw,  32'h30, 5'd2, 5'd5, 5'd0,  1'b0, 1'b0, 1'b0));
    step(mk(OpLw,  32'h34, 5'd1, 5'd0, 5'd5,  1'b0, 1'b0, 1'b0));
    step(mk(OpBr,  32'h38, 5'd1, 5'd5, 5'd0,  1'b0, 1'b1, 1'b1)); // branch rs2=x5 stalls
    step(mk(OpBr,  32'h38, 5'd1, 5'd5, 5'd0,  1'b0, 1'b0, 1'b0));
    step(mk(OpLw,  32'h3C, 5'd1, 5'd0, 5'd5,  1'b0, 1'b0, 1'b0));
    step(mk(OpI,   32'h40, 5'd5, 5'd0, 5'd11, 1'b0, 1'b1, 1'b1)); // addi rs1=x5 stalls
    step(mk(OpI,   32'h40, 5'd5, 5'd0, 5'd11, 1'b0, 1'b0, 1'b0));
    step(mk(OpLw,  32'h44, 5'd1, 5'd0, 5'd5,  1'b0, 1'b0, 1'b0));
    step(mk(OpJal, 32'h48, 5'd5, 5'd5, 5'd1,  1'b0, 1'b0, 1'b0)); // jal: no source regs
    step(mk(OpLw,  32'h4C, 5'd1, 5'd0, 5'd5,  1'b0, 1'b0, 1'b0));
    step(mk(OpBad, 32'h50, 5'd5, 5'd5, 5'd2,  1'b0, 1'b0, 1'b0)); // unknown opcode
    step(mk(OpLw,  32'h54, 5'd1, 5'd0, 5'd5,  1'b0, 1'b0, 1'b0));
    step(mk(OpR,   32'h58, 5'd5, 5'd7, 5'd6,  1'b1, 1'b0, 1'b1)); // flush beats hazard
    step(mk(OpR,   32'h5C, 5'd5, 5'd7, 5'd6,  1'b0, 1'b0, 1'b0));

    // Reset in the middle of a load-use stall.
    step(mk(OpLw,  32'h60, 5'd1, 5'd0, 5'd5,  1'b0, 1'b0, 1'b0));
    apply(mk(OpR,  32'h64, 5'd5, 5'd7, 5'd6,  1'b0, 1'b0, 1'b0));
    #1;
    check("midstall_stall_before_reset", 162'(Stall), 162'(1'b1));
    #2;
    reset = 1'b1;
    #1;
    check("midstall_ex", w_act, '0);
    check("midstall_stall", 162'(Stall), '0);
    check("midstall_cnts", 162'({bubble_cnt, flush_cnt}), '0);
    @(negedge clk);
    reset = 1'b0;
    exp_b = '0;
    exp_f = '0;
    step(mk(OpR,   32'h64, 5'd5, 5'd7, 5'd6,  1'b0, 1'b0, 1'b0));

    // Saturation: 2^16+3 consecutive flush cycles.
    flush = 1'b1;
    for (int k = 1; k <= 65539; k++) begin
      @(posedge clk);
      #1;
      if (k == 65534) check("flush_cnt_fffe", 162'(flush_cnt), 162'(16'hFFFE));
      if (k == 65535) check("flush_cnt_ffff", 162'(flush_cnt), 162'(16'hFFFF));
    end
    check("flush_cnt_no_wrap", 162'(flush_cnt), 162'(16'hFFFF));
    check("flush_sat_bubble_cnt", 162'(bubble_cnt), '0);
    check("flush_sat_valid", 162'(ex_Valid), '0);
    check("flush_sat_stall", 162'(Stall), '0);
    flush = 1'b0;
    @(negedge clk);
    check("scoreboard_drained", 162'(q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
